// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), one bit per clock, LSB first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             br;

   logic             a0;
   logic             b0;
   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;
   logic             accept;

`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   // One full-subtractor slice; the result register fills from the MSB end.
   always_comb begin
      a0       = sh_a[0];
      b0       = sh_b[0];
      d        = a0 ^ b0 ^ br;
      br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
      res_next = res >> 1;
      res_next[WIDTH-1] = d;
      accept   = start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sh_a  <= '0;
         sh_b  <= '0;
         res   <= '0;
         cnt   <= '0;
         br    <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf   <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (accept) begin
                  sh_a  <= a;
                  sh_b  <= b;
                  res   <= '0;
                  cnt   <= '0;
                  br    <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sh_a <= sh_a >> 1;
               sh_b <= sh_b >> 1;
               res  <= res_next;
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  // Publish only the completed word so diff never shows partial results.
                  diff  <= res_next;
                  bout  <= br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); checks ovf when
// SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             busy;
   logic             done;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .diff  (diff),
      .bout  (bout),
`ifdef SERIAL_SUB_OVF_EN
      .ovf   (ovf),
`endif
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation from IDLE: start in cycle 0, busy cycles 1..8, done in cycle 9.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
      a = av; b = bv; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~av; b = ~bv;
      for (int c = 1; c <= 8; c++) begin
         check("run_busy", 32'(busy), 32'd1);
         check("run_nodone", 32'(done), 32'd0);
         tick();
      end
      check("op_done", 32'(done), 32'd1);
      check("op_busy_low", 32'(busy), 32'd0);
      check("op_diff", 32'(diff), 32'(exp_d));
      check("op_bout", 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
      check("op_ovf", 32'(ovf), 32'(exp_o));
`else
      if (exp_o) begin end
`endif
      tick();
      check("op_done_pulse", 32'(done), 32'd0);
      check("op_diff_hold", 32'(diff), 32'(exp_d));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      tick();
      tick();
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      tick();

      run_op(8'd100, 8'd37,  8'h3F, 1'b0, 1'b0);
      run_op(8'd37,  8'd100, 8'hC1, 1'b1, 1'b0);
      run_op(8'h00,  8'h00,  8'h00, 1'b0, 1'b0);
      run_op(8'hFF,  8'h01,  8'hFE, 1'b0, 1'b0);
      run_op(8'h00,  8'hFF,  8'h01, 1'b1, 1'b0);
      run_op(8'h80,  8'h01,  8'h7F, 1'b0, 1'b1);
      run_op(8'h05,  8'h03,  8'h02, 1'b0, 1'b0);

      // start during RUN must be ignored
      a = 8'd100; b = 8'd37; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      a = 8'd5; b = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      check("ign_done", 32'(done), 32'd1);
      check("ign_diff", 32'(diff), 32'h3F);
      for (int c = 0; c < 12; c++) begin
         tick();
         check("ign_no_done", 32'(done), 32'd0);
         check("ign_idle", 32'(busy), 32'd0);
      end

      // back-to-back: start held in the DONE cycle
      a = 8'd100; b = 8'd37; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      check("b2b_done1", 32'(done), 32'd1);
      check("b2b_diff1", 32'(diff), 32'h3F);
      a = 8'd37; b = 8'd100; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         check("b2b_busy", 32'(busy), 32'd1);
         check("b2b_nodone", 32'(done), 32'd0);
         check("b2b_diff_hold", 32'(diff), 32'h3F);
         tick();
      end
      check("b2b_done2", 32'(done), 32'd1);
      check("b2b_diff2", 32'(diff), 32'hC1);
      check("b2b_bout2", 32'(bout), 32'd1);
      tick();
      check("b2b_pulse", 32'(done), 32'd0);

      // reset in cycle 5 of RUN aborts
      a = 8'd100; b = 8'd37; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check("mid_rst_diff", 32'(diff), 32'd0);
      check("mid_rst_bout", 32'(bout), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("mid_rst_no_done", 32'(done), 32'd0);
         check("mid_rst_idle", 32'(busy), 32'd0);
      end
      run_op(8'd9, 8'd4, 8'h05, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
